// File: rtl/uart_boot_loader_pkg.sv
// uart_boot_loader_pkg: shared constants and state encodings for the UART boot loader
package uart_boot_loader_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int MAX_WORDS_DEF = 512;
  typedef enum logic [2:0] {SYNC, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR} state_e;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
endpackage

// File: rtl/uart_boot_loader_rx.sv
// uart_rx: 8N1 serial receiver with start-bit glitch rejection and framing error flag
module uart_rx
  import uart_boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rx_valid,
  output logic       rx_ferr
);
  rx_state_e st_q, st_d;
  logic rx_prev_q;
  logic [15:0] cnt_q;
  logic [2:0] bit_q;
  logic half, full;
  assign half = cnt_q == 16'(CLKS_PER_BIT / 2 - 1);
  assign full = cnt_q == 16'(CLKS_PER_BIT - 1);
  // next receiver state: confirm start at half bit, then sample each bit at mid-bit
  always_comb begin
    st_d = st_q;
    case (st_q)
      R_IDLE:  st_d = (rx_prev_q && !rx) ? R_START : R_IDLE;
      R_START: st_d = half ? (rx ? R_IDLE : R_DATA) : R_START;
      R_DATA:  st_d = (full && bit_q == 3'd7) ? R_STOP : R_DATA;
      R_STOP:  st_d = full ? R_IDLE : R_STOP;
      default: st_d = R_IDLE;
    endcase
  end
  // state, bit timing counter, shift register and one-cycle result strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= R_IDLE;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      bit_q     <= '0;
      data      <= '0;
      rx_valid  <= 1'b0;
      rx_ferr   <= 1'b0;
    end else begin
      st_q      <= st_d;
      rx_prev_q <= rx;
      rx_valid  <= 1'b0;
      rx_ferr   <= 1'b0;
      cnt_q     <= (st_d != st_q || full) ? '0 : cnt_q + 16'd1;
      if (st_q == R_START) bit_q <= '0;
      if (st_q == R_DATA && full) begin
        data  <= {rx, data[7:1]};
        bit_q <= bit_q + 3'd1;
      end
      if (st_q == R_STOP && full) begin
        rx_valid <= rx;
        rx_ferr  <= !rx;
      end
    end
  end
endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a framed, checksummed program image over UART into instruction memory
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int MAX_WORDS    = MAX_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst_hold,
  output logic        load_done,
  output logic        load_err
);
  logic [1:0] sync_q;
  logic [7:0] rx_data;
  logic rx_valid, rx_ferr;
  state_e state_q, state_d;
  logic [15:0] len_q, word_idx_q, n_len;
  logic [7:0] chk_q;
  logic [1:0] byte_cnt_q;
  logic [31:0] word_q, addr_q, wdata_q;
  logic we_q, last;
  // two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clk) begin
    sync_q <= rst ? 2'b11 : {sync_q[0], uart_rx};
  end
  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (sync_q[1]),
    .data     (rx_data),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );
  assign n_len = {rx_data, len_q[7:0]};
  assign last  = byte_cnt_q == 2'd3 && word_idx_q == len_q - 16'd1;
  // loader state register
  always_ff @(posedge clk) begin
    state_q <= rst ? SYNC : state_d;
  end
  // loader next state; a framing error aborts any load that is not finished or failed
  always_comb begin
    state_d = state_q;
    if (rx_ferr && state_q != DONE && state_q != ERR) state_d = ERR;
    else if (rx_valid)
      case (state_q)
        SYNC:    state_d = rx_data == SYNC_BYTE ? LEN_LO : SYNC;
        LEN_LO:  state_d = LEN_HI;
        LEN_HI:  state_d = (n_len == 16'd0 || 32'(n_len) > MAX_WORDS) ? ERR : DATA;
        DATA:    state_d = last ? CHK : DATA;
        CHK:     state_d = rx_data == chk_q ? DONE : ERR;
        ERR:     state_d = rx_data == SYNC_BYTE ? LEN_LO : ERR;
        default: state_d = state_q;
      endcase
  end
  // loader outputs decoded from state
  always_comb begin
    cpu_rst_hold = state_q != DONE;
    load_done    = state_q == DONE;
    load_err     = state_q == ERR;
  end
  // length capture, little-endian word assembly, checksum and memory write strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= '0;
      word_idx_q <= '0;
      chk_q      <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if ((state_q == SYNC || state_q == ERR) && state_d == LEN_LO) begin
        word_idx_q <= '0;
        chk_q      <= '0;
        byte_cnt_q <= '0;
      end
      if (rx_valid && state_q == LEN_LO) len_q <= {8'd0, rx_data};
      if (rx_valid && state_q == LEN_HI) len_q <= n_len;
      if (rx_valid && state_q == DATA) begin
        chk_q      <= chk_q ^ rx_data;
        word_q     <= {rx_data, word_q[31:8]};
        byte_cnt_q <= byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) begin
          we_q       <= 1'b1;
          addr_q     <= {14'd0, word_idx_q, 2'b00};
          wdata_q    <= {rx_data, word_q[31:8]};
          word_idx_q <= word_idx_q + 16'd1;
        end
      end
    end
  end
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed UART image loads with a write scoreboard
module tb_uart_boot_loader;
  localparam int CPB = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rx = 1'b1;
  logic imem_we, cpu_rst_hold, load_done, load_err;
  logic [31:0] imem_addr, imem_wdata;
  int n_tests = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];
  logic [31:0] img[2] = '{32'h0000_0013, 32'h0010_0093};

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(512)) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_rx      (uart_rx),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_rst_hold (cpu_rst_hold),
    .load_done    (load_done),
    .load_err     (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic done, input logic err, input logic hold);
    check({tag, "_done"}, 32'(load_done), 32'(done));
    check({tag, "_err"}, 32'(load_err), 32'(err));
    check({tag, "_hold"}, 32'(cpu_rst_hold), 32'(hold));
  endtask

  task automatic bit_time(input logic v);
    uart_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
    bit_time(1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic load_image(input bit bad_chk);
    logic [7:0] b, chk;
    chk = 8'h00;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    for (int w = 0; w < 2; w++)
      for (int k = 0; k < 4; k++) begin
        b = img[w][8*k +: 8];
        chk = chk ^ b;
        if (k == 3) exp_q.push_back({32'(w * 4), img[w]});
        send_byte(b);
      end
    send_byte(bad_chk ? 8'h81 : chk);
  endtask

  // every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_we", 32'(imem_we), 32'd0);
      else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("wr_addr", imem_addr, e[63:32]);
        check("wr_data", imem_wdata, e[31:0]);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check_status("rst", 1'b0, 1'b0, 1'b1);

    load_image(1'b0);
    check_status("good", 1'b1, 1'b0, 1'b0);
    check("good_pending", 32'(exp_q.size()), 32'd0);
    send_byte(8'hA5);
    send_byte(8'h01);
    check_status("done_sticky", 1'b1, 1'b0, 1'b0);

    do_reset();
    load_image(1'b1);
    check_status("badchk", 1'b0, 1'b1, 1'b1);
    load_image(1'b0);
    check_status("reload", 1'b1, 1'b0, 1'b0);
    check("reload_pending", 32'(exp_q.size()), 32'd0);

    do_reset();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    check_status("len0", 1'b0, 1'b1, 1'b1);

    do_reset();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    check_status("len513", 1'b0, 1'b1, 1'b1);

    do_reset();
    uart_rx = 1'b0;
    repeat (5) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    check_status("glitch", 1'b0, 1'b0, 1'b1);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    check_status("pre_ferr", 1'b0, 1'b0, 1'b1);
    send_byte(8'h22, 1'b0);
    check_status("ferr", 1'b0, 1'b1, 1'b1);

    do_reset();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h00);
    send_byte(8'h00);
    exp_q.push_back({32'd0, 32'h0000_0013});
    send_byte(8'h00);
    send_byte(8'h93);
    check("mid_wdata_before", imem_wdata, 32'h0000_0013);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    rst = 1'b1;
    uart_rx = 1'b1;
    @(negedge clk);
    check("mid_rst_we", 32'(imem_we), 32'd0);
    check("mid_rst_addr", imem_addr, 32'd0);
    check("mid_rst_wdata", imem_wdata, 32'd0);
    check_status("mid_rst", 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    load_image(1'b0);
    check_status("after_rst", 1'b1, 1'b0, 1'b0);
    check("final_pending", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
